// File: rtl/vanilla_sb_clear_arbiter_pkg.sv
// Shared types for the scoreboard clear arbiter: channel FSM states and the
// per-requester clear request record.
package bsg_vanilla_pkg;

  localparam int RV32_reg_addr_width_gp = 5;

  typedef enum logic [0:0] {
    CHAN_NORMAL = 1'b0,
    CHAN_FORCE  = 1'b1
  } sb_clear_state_e;

  typedef struct packed {
    logic                              float;
    logic [RV32_reg_addr_width_gp-1:0] id;
  } sb_clear_req_s;

endpackage

// File: rtl/vanilla_sb_clear_channel.sv
// One scoreboard-clear channel: round-robin pick among its requesters,
// starvation counter with a NORMAL/FORCE FSM, and registered clear outputs.
module vanilla_sb_clear_channel
  import bsg_vanilla_pkg::*;
#(
  parameter int num_req_p        = 4,
  parameter int reg_addr_width_p = RV32_reg_addr_width_gp,
  parameter int starve_limit_p   = 15
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p-1:0]                  v_i,
  input  logic [num_req_p*reg_addr_width_p-1:0] id_i,
  input  logic                                  busy_i,
  output logic [num_req_p-1:0]                  yumi_o,
  output logic                                  stall_o,
  output logic                                  clear_o,
  output logic [reg_addr_width_p-1:0]           clear_id_o
);

  localparam int ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_limit_lp = cnt_width_lp'(starve_limit_p);

  sb_clear_state_e             state_d, state_q;
  logic [ptr_width_lp-1:0]     ptr_d, ptr_q, cand_s, grant_idx_s;
  logic [cnt_width_lp-1:0]     cnt_d, cnt_q;
  logic                        found_s, pending_s, grant_s;
  logic                        stall_d, stall_q, clear_d, clear_q;
  logic [reg_addr_width_p-1:0] clear_id_d, clear_id_q, id_sel_s;

  assign pending_s = |v_i;

  // Round-robin search starting at the pointer.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = {ptr_width_lp{1'b0}};
    cand_s      = {ptr_width_lp{1'b0}};
    for (int i = 0; i < num_req_p; i++) begin
      cand_s = ptr_width_lp'((int'(ptr_q) + i) % num_req_p);
      if (!found_s && v_i[cand_s]) begin
        found_s     = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Starvation FSM; the counter saturates at the limit while we move to FORCE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_s = 1'b0;
    case (state_q)
      CHAN_NORMAL: begin
        if (!pending_s) begin
          cnt_d = {cnt_width_lp{1'b0}};
        end else if (!busy_i) begin
          grant_s = 1'b1;
          cnt_d   = {cnt_width_lp{1'b0}};
        end else if (cnt_q == cnt_limit_lp) begin
          state_d = CHAN_FORCE;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      CHAN_FORCE: begin
        grant_s = pending_s;
        cnt_d   = {cnt_width_lp{1'b0}};
        state_d = CHAN_NORMAL;
      end
      default: begin
        cnt_d   = {cnt_width_lp{1'b0}};
        state_d = CHAN_NORMAL;
      end
    endcase
    grant_s = grant_s & reset_n_i;
  end

  // Grant side effects: pointer advance and the ID captured for next cycle.
  always_comb begin
    id_sel_s = {reg_addr_width_p{1'b0}};
    for (int k = 0; k < num_req_p; k++) begin
      if (grant_idx_s == ptr_width_lp'(k)) begin
        id_sel_s = id_i[k*reg_addr_width_p +: reg_addr_width_p];
      end else begin
        id_sel_s = id_sel_s;
      end
    end
    if (grant_s) begin
      ptr_d      = ptr_width_lp'((int'(grant_idx_s) + 1) % num_req_p);
      clear_id_d = id_sel_s;
    end else begin
      ptr_d      = ptr_q;
      clear_id_d = clear_id_q;
    end
    clear_d = grant_s;
    stall_d = (state_d == CHAN_FORCE);
  end

  // Channel state and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= CHAN_NORMAL;
      cnt_q      <= {cnt_width_lp{1'b0}};
      ptr_q      <= {ptr_width_lp{1'b0}};
      stall_q    <= 1'b0;
      clear_q    <= 1'b0;
      clear_id_q <= {reg_addr_width_p{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      stall_q    <= stall_d;
      clear_q    <= clear_d;
      clear_id_q <= clear_id_d;
    end
  end

  assign yumi_o     = grant_s ? (num_req_p'(1'b1) << grant_idx_s) : {num_req_p{1'b0}};
  assign stall_o    = stall_q;
  assign clear_o    = clear_q;
  assign clear_id_o = clear_id_q;

endmodule

// File: rtl/vanilla_sb_clear_arbiter.sv
// Scoreboard clear arbiter: splits requesters into independent int and float
// channels by their float flag and merges the per-channel yumis.
module vanilla_sb_clear_arbiter
  import bsg_vanilla_pkg::*;
#(
  parameter int num_req_p        = 4,
  parameter int reg_addr_width_p = RV32_reg_addr_width_gp,
  parameter int starve_limit_p   = 15
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p-1:0]                  req_float_i,
  input  logic [num_req_p*reg_addr_width_p-1:0] req_id_i,
  output logic [num_req_p-1:0]                  req_yumi_o,
  input  logic                                  int_port_busy_i,
  input  logic                                  float_port_busy_i,
  output logic                                  int_stall_o,
  output logic                                  float_stall_o,
  output logic                                  int_sb_clear_o,
  output logic [reg_addr_width_p-1:0]           int_sb_clear_id_o,
  output logic                                  float_sb_clear_o,
  output logic [reg_addr_width_p-1:0]           float_sb_clear_id_o
);

  logic [num_req_p-1:0] int_v_s, float_v_s, int_yumi_s, float_yumi_s;

  assign int_v_s   = req_v_i & ~req_float_i;
  assign float_v_s = req_v_i &  req_float_i;

  vanilla_sb_clear_channel #(
    .num_req_p(num_req_p), .reg_addr_width_p(reg_addr_width_p), .starve_limit_p(starve_limit_p)
  ) int_chan (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(int_v_s), .id_i(req_id_i),
    .busy_i(int_port_busy_i), .yumi_o(int_yumi_s), .stall_o(int_stall_o),
    .clear_o(int_sb_clear_o), .clear_id_o(int_sb_clear_id_o)
  );

  vanilla_sb_clear_channel #(
    .num_req_p(num_req_p), .reg_addr_width_p(reg_addr_width_p), .starve_limit_p(starve_limit_p)
  ) float_chan (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(float_v_s), .id_i(req_id_i),
    .busy_i(float_port_busy_i), .yumi_o(float_yumi_s), .stall_o(float_stall_o),
    .clear_o(float_sb_clear_o), .clear_id_o(float_sb_clear_id_o)
  );

  assign req_yumi_o = int_yumi_s | float_yumi_s;

endmodule

// File: tb/tb_vanilla_sb_clear_arbiter.sv
// Scoreboard bench for vanilla_sb_clear_arbiter: directed scenarios plus a
// randomized phase, checked against a rule-level reference model.
module tb_vanilla_sb_clear_arbiter;

  localparam int N     = 4;
  localparam int W     = 5;
  localparam int LIMIT = 15;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [N-1:0]   req_v_i, req_float_i, req_yumi_o;
  logic [N*W-1:0] req_id_i;
  logic           int_port_busy_i, float_port_busy_i;
  logic           int_stall_o, float_stall_o;
  logic           int_sb_clear_o, float_sb_clear_o;
  logic [W-1:0]   int_sb_clear_id_o, float_sb_clear_id_o;

  vanilla_sb_clear_arbiter #(.num_req_p(N), .reg_addr_width_p(W), .starve_limit_p(LIMIT)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_float_i(req_float_i), .req_id_i(req_id_i), .req_yumi_o(req_yumi_o),
    .int_port_busy_i(int_port_busy_i), .float_port_busy_i(float_port_busy_i),
    .int_stall_o(int_stall_o), .float_stall_o(float_stall_o),
    .int_sb_clear_o(int_sb_clear_o), .int_sb_clear_id_o(int_sb_clear_id_o),
    .float_sb_clear_o(float_sb_clear_o), .float_sb_clear_id_o(float_sb_clear_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int due; logic [W-1:0] id; } exp_t;
  exp_t         q_int[$], q_fl[$];
  logic [W-1:0] last_int, last_fl;
  int           cyc = 0;
  int           n_checks = 0, n_fail = 0;
  int           m_ptr[2], m_cnt[2];
  bit           m_force[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_ptr[c] = 0; m_cnt[c] = 0; m_force[c] = 1'b0;
    end
    q_int.delete(); q_fl.delete();
    last_int = '0; last_fl = '0;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_int_clr"}, 32'(int_sb_clear_o), 32'd0);
    check({tag, "_fl_clr"}, 32'(float_sb_clear_o), 32'd0);
    check({tag, "_int_id"}, 32'(int_sb_clear_id_o), 32'd0);
    check({tag, "_fl_id"}, 32'(float_sb_clear_id_o), 32'd0);
    check({tag, "_stall"}, 32'({int_stall_o, float_stall_o}), 32'd0);
    check({tag, "_yumi"}, 32'(req_yumi_o), 32'd0);
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Monitor: pops expected clears when due; otherwise no pulse and ID held.
  initial forever begin
    @(negedge clk_i);
    if (reset_n_i === 1'b1) begin
      if (q_int.size() > 0 && q_int[0].due == cyc) begin
        check("int_clr_pulse", 32'(int_sb_clear_o), 32'd1);
        check("int_clr_id", 32'(int_sb_clear_id_o), 32'(q_int[0].id));
        last_int = q_int[0].id;
        void'(q_int.pop_front());
      end else begin
        check("int_clr_idle", 32'(int_sb_clear_o), 32'd0);
        check("int_id_hold", 32'(int_sb_clear_id_o), 32'(last_int));
      end
      if (q_fl.size() > 0 && q_fl[0].due == cyc) begin
        check("fl_clr_pulse", 32'(float_sb_clear_o), 32'd1);
        check("fl_clr_id", 32'(float_sb_clear_id_o), 32'(q_fl[0].id));
        last_fl = q_fl[0].id;
        void'(q_fl.pop_front());
      end else begin
        check("fl_clr_idle", 32'(float_sb_clear_o), 32'd0);
        check("fl_id_hold", 32'(float_sb_clear_id_o), 32'(last_fl));
      end
    end
  end

  // One cycle: drive, predict grants from the rules, check, advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] fl, input logic [N*W-1:0] ids,
                      input logic ib, input logic fb, input bit pre_rst,
                      output logic [N-1:0] exp_y, output logic [N-1:0] dut_y, output logic [1:0] dut_st);
    logic [N-1:0] mask;
    logic         bsy;
    int           win, idx;
    exp_t         e;
    req_v_i = v; req_float_i = fl; req_id_i = ids;
    int_port_busy_i = ib; float_port_busy_i = fb;
    #3;
    exp_y  = '0;
    dut_y  = req_yumi_o;
    dut_st = {float_stall_o, int_stall_o};
    check("int_stall", 32'(int_stall_o), 32'(m_force[0]));
    check("fl_stall", 32'(float_stall_o), 32'(m_force[1]));
    for (int ch = 0; ch < 2; ch++) begin
      mask = v & ((ch == 1) ? fl : ~fl);
      bsy  = (ch == 1) ? fb : ib;
      win  = -1;
      if (mask != 0 && (m_force[ch] || !bsy)) begin
        for (int j = 0; j < N; j++) begin
          idx = (m_ptr[ch] + j) % N;
          if (win < 0 && mask[idx]) win = idx;
        end
      end
      if (win >= 0) begin
        exp_y[win] = 1'b1;
        e.due = cyc + 1;
        e.id  = ids[win*W +: W];
        if (ch == 1) q_fl.push_back(e); else q_int.push_back(e);
        m_ptr[ch] = (win + 1) % N;
      end
      if (m_force[ch] || mask == 0 || win >= 0) begin
        m_force[ch] = 1'b0;
        m_cnt[ch]   = 0;
      end else if (m_cnt[ch] == LIMIT) begin
        m_force[ch] = 1'b1;
      end else begin
        m_cnt[ch]++;
      end
    end
    check("yumi", 32'(req_yumi_o), 32'(exp_y));
    if (pre_rst) begin
      #3;
      reset_n_i = 1'b0;
      model_reset();
      #1;
      check_zero("rst_async");
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic rst_hold();
    check_zero("rst_hold0");
    @(posedge clk_i); #1;
    check_zero("rst_hold1");
    reset_n_i = 1'b1;
  endtask

  logic [N-1:0]   ey, dy;
  logic [1:0]     ds;
  logic [N*W-1:0] ids;
  bit             act[N], rfl[N];
  logic [W-1:0]   rid[N];

  initial begin
    int first_st, grant_at, n_int, n_fl, fl_st, mode;
    logic ib, fb;
    logic [N-1:0] v, fl;
    reset_n_i = 1'b0;
    req_v_i = 4'b1111; req_float_i = 4'b0101; req_id_i = 20'hABCDE;
    int_port_busy_i = 1'b0; float_port_busy_i = 1'b0;
    model_reset();
    #3;
    check_zero("rst_init");
    @(posedge clk_i); #1;
    rst_hold();

    // Int round-robin over all four requesters
    for (int k = 0; k < N; k++) ids[k*W +: W] = W'(k + 10);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);
      check("rr_order", 32'(dy), 32'(4'b0001 << (i % 4)));
    end

    // Dual channel grant in one cycle
    step(4'b0011, 4'b0010, {5'd0, 5'd0, 5'd7, 5'd3}, 1'b0, 1'b0, 0, ey, dy, ds);
    check("dual_yumi", 32'(dy), 32'(4'b0011));
    check("dual_int_clr", 32'({int_sb_clear_o, int_sb_clear_id_o}), 32'({1'b1, 5'd3}));
    check("dual_fl_clr", 32'({float_sb_clear_o, float_sb_clear_id_o}), 32'({1'b1, 5'd7}));
    step(4'b0000, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);

    // Starvation on int while float keeps flowing
    first_st = -1; grant_at = -1; n_int = 0; n_fl = 0; fl_st = 0;
    for (int i = 0; i <= LIMIT + 1; i++) begin
      step(4'b0101, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd9}, 1'b1, 1'b0, 0, ey, dy, ds);
      if (ds[0] && first_st < 0) first_st = i;
      if (dy[0] && grant_at < 0) grant_at = i;
      n_int += int'(dy[0]);
      n_fl  += int'(dy[2]);
      fl_st += int'(ds[1]);
    end
    check("starve_stall_cycle", 32'(first_st), 32'(LIMIT + 1));
    check("starve_grant_cycle", 32'(grant_at), 32'(LIMIT + 1));
    check("starve_one_grant", 32'(n_int), 32'd1);
    check("starve_fl_grants", 32'(n_fl), 32'(LIMIT + 2));
    check("starve_fl_stall", 32'(fl_st), 32'd0);
    step(4'b0000, 4'b0000, ids, 1'b1, 1'b0, 0, ey, dy, ds);
    check("starve_back_normal", 32'(ds[0]), 32'd0);

    // Busy release at count 9, then the counter must start again from zero
    for (int i = 0; i < 9; i++) step(4'b0001, 4'b0000, ids, 1'b1, 1'b0, 0, ey, dy, ds);
    step(4'b0001, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);
    check("release_grant", 32'(dy), 32'(4'b0001));
    check("release_no_stall", 32'(ds), 32'd0);
    first_st = -1;
    for (int i = 0; i <= LIMIT + 1; i++) begin
      step(4'b0001, 4'b0000, ids, 1'b1, 1'b0, 0, ey, dy, ds);
      if (ds[0] && first_st < 0) first_st = i;
    end
    check("release_cnt_restart", 32'(first_st), 32'(LIMIT + 1));
    step(4'b0000, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);

    // Pointer wrap: pointer to 3, then only requester 1 valid
    step(4'b0100, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);
    step(4'b0010, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);
    check("wrap_grant1", 32'(dy), 32'(4'b0010));
    step(4'b1111, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);
    check("wrap_ptr2", 32'(dy), 32'(4'b0100));

    // Reset right after a grant: clear is dropped, pointer back at 0
    step(4'b0010, 4'b0000, ids, 1'b0, 1'b0, 1, ey, dy, ds);
    check("rst_pre_grant", 32'(dy), 32'(4'b0010));
    rst_hold();
    step(4'b1111, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);
    check("rst_first_grant", 32'(dy), 32'(4'b0001));
    step(4'b0000, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);

    // Randomized requesters with phases of light busy, int starve, float starve
    for (int k = 0; k < N; k++) act[k] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      mode = (c / 60) % 3;
      for (int k = 0; k < N; k++) begin
        if (!act[k] && $urandom_range(0, 1) == 1) begin
          act[k] = 1'b1;
          rfl[k] = 1'($urandom_range(0, 1));
          rid[k] = W'($urandom_range(0, 31));
        end
        v[k] = act[k]; fl[k] = rfl[k]; ids[k*W +: W] = rid[k];
      end
      ib = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      fb = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      step(v, fl, ids, ib, fb, c == 333, ey, dy, ds);
      if (c == 333) rst_hold();
      for (int k = 0; k < N; k++) if (ey[k]) act[k] = 1'b0;
    end

    step(4'b0000, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);
    step(4'b0000, 4'b0000, ids, 1'b0, 1'b0, 0, ey, dy, ds);
    check("drain_int_q", 32'(q_int.size()), 32'd0);
    check("drain_fl_q", 32'(q_fl.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
